player_ctrl: RTL
================

# player_ctrl

Per-player input controller for the artillery game core, the parametrised successor of the fixed 5-bit position/aim block. It keeps a saturating horizontal position and a 7-step aim index, adds hold-to-auto-repeat on both axes, and adds a fire path. The fire path latches a shot descriptor (x, run, rise, dir) and offers it to the projectile engine over a valid/ready handshake, with a cooldown between shots. One instance exists per player, between the button debouncers and the projectile/render logic.

## Interface
Parameters:
- X_W, 5: position width.
- X_MAX, 31: upper position bound. Lower bound is 0. Requires X_MAX ≤ 2^X_W−1.
- X_RESET, 0: position after reset.
- AIM_RESET, 3: aim index after reset (vertical).
- REPEAT_DLY, 8: ena ticks from the first step to the first auto-repeat step. Must be ≥1.
- REPEAT_PER, 2: ena ticks between later repeat steps. Must be ≥1.
- COOLDOWN, 16: ena ticks after a shot is accepted before the next fire press is honoured. 0 is legal.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-high reset.
- ena, in, 1: game tick. All button sampling and counting happens only on ena=1 cycles.
- left_x / right_x, in, 1: move left/right.
- left_aim / right_aim, in, 1: decrement/increment aim.
- fire, in, 1: fire button.
- shot_ready, in, 1: projectile engine accepts a shot.
- x_pos, out, X_W: current position.
- aim_pos, out, 3: aim index, 0..6.
- run, rise, out, 5: slope of the current aim.
- dir, out, 1: 0 = right-leaning, 1 = left-leaning.
- shot_valid, out, 1: a shot descriptor is offered.
- shot_x, out, X_W; shot_run, shot_rise, out, 5; shot_dir, out, 1: the latched descriptor.
- cooling, out, 1: fire FSM is in COOL.

## Operation
- Aim table, combinational from aim_pos, as (dir, run, rise):
  - 0: (0, 2, 1)
  - 1: (0, 1, 1)
  - 2: (0, 1, 2)
  - 3: (0, 0, 1)
  - 4: (1, 1, 2)
  - 5: (1, 1, 1)
  - 6: (1, 2, 1)
  - 7: unreachable; outputs (0, 0, 0).
- Axis stepping (identical for x and aim; bounds 0..X_MAX for x and 0..6 for aim):
  - Direction: left-only is −1, right-only is +1.
  - Both or neither pressed counts as "released": the repeat counter clears and no step is taken.
  - Press edge: on an ena tick where the direction differs from the direction sampled on the previous ena tick. Step once and load cnt=REPEAT_DLY.
  - Held, same direction: if cnt==1, step and load cnt=REPEAT_PER; otherwise decrement cnt.
  - Steps saturate at the bounds. The counter keeps running while clamped.
  - Reversing direction directly counts as a new press edge.
- Fire FSM, states READY, ARMED, COOL:
  - READY: a fire press edge on an ena tick latches the descriptor from the current x_pos/run/rise/dir and moves to ARMED.
  - ARMED: shot_valid=1 and the descriptor is held stable. Movement and aim keep updating, but only the live outputs change.
  - ARMED to COOL: when shot_valid & shot_ready on any clk (ena not required). Loads cnt=COOLDOWN, or goes straight to READY if COOLDOWN=0.
  - COOL: decrement on ena ticks; when cnt reaches 0, go to READY.
  - Fire presses in ARMED or COOL are dropped, not queued. Holding fire never auto-fires; a new edge is required.
- Reset (asynchronous, any state, including mid-handshake):
  - x_pos=X_RESET, aim_pos=AIM_RESET.
  - Repeat counters and previous-direction samples cleared.
  - Fire FSM in READY; shot_valid=0 and cooling=0 immediately.
  - shot_x/run/rise/dir=0.

## Timing
- x_pos and aim_pos change on the clk edge that ends the qualifying ena cycle: one-cycle latency. run/rise/dir follow aim_pos combinationally.
- Holding a button from tick t steps at t, t+REPEAT_DLY, then every REPEAT_PER ticks after that.
- shot_valid rises on the clk edge ending the fire-edge ena cycle. It falls on the clk edge ending the first valid&ready cycle.
- The first fire edge honoured after acceptance comes at least COOLDOWN ena ticks later.
- With ena=0, all state holds except the ARMED→COOL handshake.

## Configuration
- PLAYER_AUTO_REPEAT_EN:
  - Defined: auto-repeat as described above.
  - Undefined: repeat counters are not built, and each press edge yields exactly one step. Fire behaviour is unchanged.

## Structure
- player_pkg holds:
  - the aim table constant (7 entries of dir/run/rise) and AIM_MAX=6;
  - the fire-state enum (READY, ARMED, COOL);
  - a direction enum (NONE, DEC, INC).
- One sub-module, axis_stepper:
  - parameters: width, max, reset value, REPEAT_DLY, REPEAT_PER;
  - instantiated twice, once for x and once for aim;
  - contains the edge detector, repeat counter and saturating step.

## Test plan
- Reset, then a 1-tick right_x pulse: x_pos 0→1; aim_pos=3, run=0, rise=1, dir=0.
- right_x held 20 ticks (DLY=8, PER=2): steps at ticks 0, 8, 10, 12, 14, 16, 18, so x_pos=7. Without the macro: x_pos=1.
- x_pos=31, right held: stays 31. aim_pos=0, left_aim pulse: stays 0. Aim 6 reads (1, 2, 1).
- left_x and right_x held together: no movement. Release right: left press edge, x decrements once.
- Fire at x=12, aim=5, shot_ready=0 for 5 cycles while moving to x=14: shot_valid=1 and shot_x=12, (1, 1, 1) stable. Assert ready: valid drops next edge, cooling=1. A fire press 10 ticks later is ignored. A press after 16 ticks is accepted.
- Assert reset while ARMED: shot_valid and cooling go to 0 asynchronously; x_pos=X_RESET and aim_pos=3 after release.

Source files
------------

// File: rtl/player_pkg.sv
// player_pkg: shared types and constants for the per-player input controller.
//   AIM_MAX      highest reachable aim index
//   aim_t        slope descriptor (dir, run, rise)
//   AIM_TABLE    aim index -> slope descriptor
//   fire_state_e fire FSM states
//   dir_e        sampled button direction for one axis
package player_pkg;

    localparam int unsigned AIM_MAX = 6;

    typedef struct packed {
        logic       dir;
        logic [4:0] run;
        logic [4:0] rise;
    } aim_t;

    // Entries 0..6 are the reachable aims; entry 7 exists only so a 3-bit
    // index always selects a defined (all-zero) slope.
    localparam aim_t AIM_TABLE [8] = '{
        '{1'b0, 5'd2, 5'd1},
        '{1'b0, 5'd1, 5'd1},
        '{1'b0, 5'd1, 5'd2},
        '{1'b0, 5'd0, 5'd1},
        '{1'b1, 5'd1, 5'd2},
        '{1'b1, 5'd1, 5'd1},
        '{1'b1, 5'd2, 5'd1},
        '{1'b0, 5'd0, 5'd0}
    };

    typedef enum logic [1:0] {READY, ARMED, COOL} fire_state_e;

    typedef enum logic [1:0] {NONE, DEC, INC} dir_e;

    function automatic aim_t aim_lookup(input logic [2:0] idx);
        return AIM_TABLE[idx];
    endfunction

endpackage

// File: rtl/player_ctrl_if.sv
// player_ctrl_if: shot handshake between a player controller and the
// projectile engine.
//   shot_valid/shot_ready           valid/ready handshake
//   shot_x, shot_run, shot_rise,
//   shot_dir                        latched shot descriptor
// master = player controller, slave = projectile engine.
interface player_ctrl_if #(
    parameter int unsigned X_W = 5
);
    logic           shot_valid;
    logic           shot_ready;
    logic [X_W-1:0] shot_x;
    logic [4:0]     shot_run;
    logic [4:0]     shot_rise;
    logic           shot_dir;

    modport master (
        output shot_valid, shot_x, shot_run, shot_rise, shot_dir,
        input  shot_ready
    );

    modport slave (
        input  shot_valid, shot_x, shot_run, shot_rise, shot_dir,
        output shot_ready
    );
endinterface

// File: rtl/axis_stepper.sv
// axis_stepper: one saturating axis (position or aim) driven by a dec/inc
// button pair, with press-edge detection and optional hold-to-repeat.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   ena          game tick; sampling and counting only when high
//   dec, inc     step down / up buttons (both or neither = released)
//   pos          current position, 0..MAX
// Config macro: PLAYER_AUTO_REPEAT_EN builds the repeat counter; without it
// every press edge yields exactly one step.
module axis_stepper
    import player_pkg::*;
#(
    parameter int unsigned W          = 5,
    parameter int unsigned MAX        = 31,
    parameter int unsigned RST        = 0,
    parameter int unsigned REPEAT_DLY = 8,
    parameter int unsigned REPEAT_PER = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ena,
    input  logic         dec,
    input  logic         inc,
    output logic [W-1:0] pos
);

    if (REPEAT_DLY < 1 || REPEAT_PER < 1 || MAX > (2 ** W) - 1) begin : g_param_check
        $error("axis_stepper: illegal parameter set");
    end

    dir_e         cur;
    dir_e         prev;
    logic         step;
    logic [W-1:0] pos_next;

    always_comb begin
        cur = NONE;
        if (dec && !inc)
            cur = DEC;
        else if (inc && !dec)
            cur = INC;
    end

`ifdef PLAYER_AUTO_REPEAT_EN
    localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] cnt;

    always_comb
        step = ena && (cur != NONE) && ((cur != prev) || (cnt == CNT_W'(1)));

    // The counter keeps running while the position is clamped at a bound.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (ena) begin
            if (cur == NONE)
                cnt <= '0;
            else if (cur != prev)
                cnt <= CNT_W'(REPEAT_DLY);
            else if (cnt == CNT_W'(1))
                cnt <= CNT_W'(REPEAT_PER);
            else if (cnt != '0)
                cnt <= cnt - CNT_W'(1);
        end
    end
`else
    always_comb
        step = ena && (cur != NONE) && (cur != prev);
`endif

    always_comb begin
        pos_next = pos;
        if (cur == DEC && pos != '0)
            pos_next = pos - W'(1);
        else if (cur == INC && pos < W'(MAX))
            pos_next = pos + W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= NONE;
            pos  <= W'(RST);
        end else if (ena) begin
            prev <= cur;
            if (step)
                pos <= pos_next;
        end
    end

endmodule

// File: rtl/player_ctrl.sv
// player_ctrl: per-player input controller. Saturating x position and aim
// index with hold-to-repeat, aim slope lookup, and a fire path that offers a
// latched shot descriptor over a valid/ready handshake with a cooldown.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   ena                           game tick
//   left_x, right_x               move left / right
//   left_aim, right_aim           aim decrement / increment
//   fire                          fire button
//   x_pos, aim_pos                live position and aim index
//   run, rise, dir                live slope of the current aim
//   cooling                       fire FSM is in COOL
//   shot (player_ctrl_if.master)  shot_valid/shot_ready + descriptor
// Config macro: PLAYER_AUTO_REPEAT_EN enables auto-repeat on both axes.
module player_ctrl
    import player_pkg::*;
#(
    parameter int unsigned X_W        = 5,
    parameter int unsigned X_MAX      = 31,
    parameter int unsigned X_RESET    = 0,
    parameter int unsigned AIM_RESET  = 3,
    parameter int unsigned REPEAT_DLY = 8,
    parameter int unsigned REPEAT_PER = 2,
    parameter int unsigned COOLDOWN   = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ena,
    input  logic           left_x,
    input  logic           right_x,
    input  logic           left_aim,
    input  logic           right_aim,
    input  logic           fire,
    output logic [X_W-1:0] x_pos,
    output logic [2:0]     aim_pos,
    output logic [4:0]     run,
    output logic [4:0]     rise,
    output logic           dir,
    output logic           cooling,
    player_ctrl_if.master  shot
);

    localparam int unsigned CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    axis_stepper #(
        .W          (X_W),
        .MAX        (X_MAX),
        .RST        (X_RESET),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_x (
        .clk   (clk),
        .reset (reset),
        .ena   (ena),
        .dec   (left_x),
        .inc   (right_x),
        .pos   (x_pos)
    );

    axis_stepper #(
        .W          (3),
        .MAX        (AIM_MAX),
        .RST        (AIM_RESET),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_aim (
        .clk   (clk),
        .reset (reset),
        .ena   (ena),
        .dec   (left_aim),
        .inc   (right_aim),
        .pos   (aim_pos)
    );

    aim_t live_aim;

    always_comb begin
        live_aim = aim_lookup(aim_pos);
        run      = live_aim.run;
        rise     = live_aim.rise;
        dir      = live_aim.dir;
    end

    // Fire path
    fire_state_e     state;
    fire_state_e     state_next;
    logic            fire_prev;
    logic            fire_edge;
    logic [CD_W-1:0] cd_cnt;
    logic [X_W-1:0]  desc_x;
    aim_t            desc_aim;

    assign fire_edge = ena && fire && !fire_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= READY;
        else
            state <= state_next;
    end

    // ARMED->COOL is the only transition that does not wait for ena.
    always_comb begin
        state_next = state;
        unique case (state)
            READY: if (fire_edge) state_next = ARMED;
            ARMED: if (shot.shot_ready) state_next = (COOLDOWN == 0) ? READY : COOL;
            COOL:  if (ena && cd_cnt <= CD_W'(1)) state_next = READY;
            default: state_next = READY;
        endcase
    end

    always_comb begin
        shot.shot_valid = (state == ARMED);
        cooling         = (state == COOL);
        shot.shot_x     = desc_x;
        shot.shot_run   = desc_aim.run;
        shot.shot_rise  = desc_aim.rise;
        shot.shot_dir   = desc_aim.dir;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fire_prev <= 1'b0;
            cd_cnt    <= '0;
            desc_x    <= '0;
            desc_aim  <= '0;
        end else begin
            if (ena)
                fire_prev <= fire;
            if (state == READY && fire_edge) begin
                desc_x   <= x_pos;
                desc_aim <= live_aim;
            end
            if (state == ARMED && shot.shot_ready)
                cd_cnt <= CD_W'(COOLDOWN);
            else if (state == COOL && ena && cd_cnt != '0)
                cd_cnt <= cd_cnt - CD_W'(1);
        end
    end

endmodule
